// File: rtl/cpu_param_pkg.sv
// Shared types and encodings for the parametrised accumulator CPU.
// The optional X post-increment is selected by CPU_PARAM_XINC_EN.
package cpu_param_pkg;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_IMM,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SHR
  } alu_op_t;

  localparam logic [2:0] DST_A   = 3'd0;
  localparam logic [2:0] DST_B   = 3'd1;
  localparam logic [2:0] DST_X   = 3'd2;
  localparam logic [2:0] DST_Q   = 3'd3;
  localparam logic [2:0] DST_MEM = 3'd4;
  localparam logic [2:0] DST_JMP = 3'd5;
  localparam logic [2:0] DST_JZ  = 3'd6;
  localparam logic [2:0] DST_JC  = 3'd7;

  localparam logic [2:0] SRC_IMM = 3'd0;
  localparam logic [2:0] SRC_MEM = 3'd1;
  localparam logic [2:0] SRC_A   = 3'd2;
  localparam logic [2:0] SRC_B   = 3'd3;
  localparam logic [2:0] SRC_X   = 3'd4;
  localparam logic [2:0] SRC_ADD = 3'd5;
  localparam logic [2:0] SRC_SUB = 3'd6;
  localparam logic [2:0] SRC_SHR = 3'd7;

  localparam int IR_DST_HI = 7;
  localparam int IR_DST_LO = 5;
  localparam int IR_SRC_HI = 4;
  localparam int IR_SRC_LO = 2;
  localparam int IR_XINC   = 1;
  localparam int IR_HALT   = 0;

  function automatic logic is_alu_src(input logic [2:0] src);
    return (src == SRC_ADD) || (src == SRC_SUB) || (src == SRC_SHR);
  endfunction

endpackage

// File: rtl/alu_param.sv
// Combinational add/subtract/shift-right for the accumulator CPU.
// Subtract carry is the no-borrow flag (a >= b unsigned).
module alu_param
  import cpu_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_t          i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  localparam logic [WIDTH:0] LP_ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + LP_ONE;

  always_comb begin
    o_result = w_sum[WIDTH-1:0];
    o_carry  = w_sum[WIDTH];
    case (i_op)
      ALU_SUB: begin
        o_result = w_diff[WIDTH-1:0];
        o_carry  = w_diff[WIDTH];
      end
      ALU_SHR: begin
        o_result = {1'b0, i_a[WIDTH-1:1]};
        o_carry  = i_a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_param.sv
// Multi-cycle accumulator CPU with req/ack program and data memory ports.
// Define CPU_PARAM_XINC_EN to enable the ir[1] X post-increment.
//
// state | meaning
// FETCH | read instruction at pc, pc += 1
// IMM   | read immediate at pc, pc += 1, write dest (MEM dest continues in EXEC)
// EXEC  | register/ALU move or data-memory access, write dest
// HALT  | idle until reset
module cpu_param
  import cpu_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetBar,
  output logic             pmem_req,
  output logic [WIDTH-1:0] pmem_addr,
  input  logic             pmem_ack,
  input  logic [WIDTH-1:0] pmem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] areg,
  output logic [WIDTH-1:0] breg,
  output logic [WIDTH-1:0] xreg,
  output logic [WIDTH-1:0] qreg,
  output logic [7:0]       ir,
  output logic             qwrite,
  output logic             halted
);

  localparam logic [WIDTH-1:0] LP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_pc, r_a, r_b, r_x, r_q, r_imm;
  logic [7:0]       r_ir;
  logic             r_carry;
  logic             r_qwrite;

  logic [2:0]       w_dst, w_src, w_fetch_src;
  logic             w_mem_op, w_fetch_ack, w_imm_ack, w_done;
  logic             w_jump, w_zero, w_x_wr, w_alu_carry;
  logic [WIDTH-1:0] w_src_val, w_alu_res, w_x_next;
  alu_op_t          w_alu_op;

  assign w_dst       = r_ir[IR_DST_HI:IR_DST_LO];
  assign w_src       = r_ir[IR_SRC_HI:IR_SRC_LO];
  assign w_fetch_src = pmem_rdata[IR_SRC_HI:IR_SRC_LO];
  assign w_mem_op    = (w_src == SRC_MEM) || (w_dst == DST_MEM);
  assign w_zero      = (r_a == '0);

  assign w_fetch_ack = (r_state == ST_FETCH) && pmem_ack;
  assign w_imm_ack   = (r_state == ST_IMM) && pmem_ack;
  // An immediate bound for memory is parked in r_imm and written from EXEC.
  assign w_done      = (w_imm_ack && (w_dst != DST_MEM)) ||
                       ((r_state == ST_EXEC) && (!w_mem_op || dmem_ack));

  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_src == SRC_SUB) w_alu_op = ALU_SUB;
    if (w_src == SRC_SHR) w_alu_op = ALU_SHR;
  end

  alu_param #(.WIDTH(WIDTH)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (w_alu_op),
    .o_result (w_alu_res),
    .o_carry  (w_alu_carry)
  );

  always_comb begin
    w_src_val = w_alu_res;
    case (w_src)
      SRC_IMM: w_src_val = (r_state == ST_IMM) ? pmem_rdata : r_imm;
      SRC_MEM: w_src_val = dmem_rdata;
      SRC_A:   w_src_val = r_a;
      SRC_B:   w_src_val = r_b;
      SRC_X:   w_src_val = r_x;
      default: ;
    endcase
  end

  always_comb begin
    w_jump = 1'b0;
    case (w_dst)
      DST_JMP: w_jump = 1'b1;
      DST_JZ:  w_jump = w_zero;
      DST_JC:  w_jump = r_carry;
      default: ;
    endcase
  end

`ifdef CPU_PARAM_XINC_EN
  logic [WIDTH-1:0] w_x_base;
  assign w_x_base = (w_dst == DST_X) ? w_src_val : r_x;
  assign w_x_wr   = w_done && ((w_dst == DST_X) || r_ir[IR_XINC]);
  assign w_x_next = w_x_base + {{(WIDTH-1){1'b0}}, r_ir[IR_XINC]};
`else
  assign w_x_wr   = w_done && (w_dst == DST_X);
  assign w_x_next = w_src_val;
`endif

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) r_state <= ST_FETCH;
    else           r_state <= w_next;
  end

  // Requests are gated by resetBar so they drop the moment reset asserts.
  always_comb begin
    w_next   = r_state;
    pmem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        pmem_req = resetBar;
        if (pmem_ack) w_next = (w_fetch_src == SRC_IMM) ? ST_IMM : ST_EXEC;
      end
      ST_IMM: begin
        pmem_req = resetBar;
        if (w_imm_ack) begin
          if (w_dst == DST_MEM)    w_next = ST_EXEC;
          else if (r_ir[IR_HALT]) w_next = ST_HALT;
          else                    w_next = ST_FETCH;
        end
      end
      ST_EXEC: begin
        dmem_req = resetBar && w_mem_op;
        dmem_we  = resetBar && (w_dst == DST_MEM) && (w_src != SRC_MEM);
        if (w_done) w_next = r_ir[IR_HALT] ? ST_HALT : ST_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      r_pc     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_x      <= '0;
      r_q      <= '0;
      r_imm    <= '0;
      r_ir     <= '0;
      r_carry  <= 1'b0;
      r_qwrite <= 1'b0;
    end else begin
      r_qwrite <= w_done && (w_dst == DST_Q);
      if (w_fetch_ack) begin
        r_ir <= pmem_rdata[7:0];
        r_pc <= r_pc + LP_ONE;
      end
      if (w_imm_ack) begin
        r_imm <= pmem_rdata;
        r_pc  <= r_pc + LP_ONE;
      end
      if (w_done) begin
        case (w_dst)
          DST_A:   r_a <= w_src_val;
          DST_B:   r_b <= w_src_val;
          DST_Q:   r_q <= w_src_val;
          default: ;
        endcase
        // A taken jump wins over the immediate's pc increment above.
        if (w_jump) r_pc <= w_src_val;
        if (is_alu_src(w_src)) r_carry <= w_alu_carry;
      end
      if (w_x_wr) r_x <= w_x_next;
    end
  end

  assign pmem_addr  = r_pc;
  assign dmem_addr  = r_x;
  assign dmem_wdata = w_src_val;
  assign pc         = r_pc;
  assign areg       = r_a;
  assign breg       = r_b;
  assign xreg       = r_x;
  assign qreg       = r_q;
  assign ir         = r_ir;
  assign qwrite     = r_qwrite;
  assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu_param.sv
// Scoreboard bench for cpu_param at WIDTH=8 with wait-state memory models.
module tb_cpu_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetBar = 1'b0;
  logic         pmem_req, dmem_req, dmem_we, qwrite, halted;
  logic [W-1:0] pmem_addr, dmem_addr, dmem_wdata;
  logic [W-1:0] pc, areg, breg, xreg, qreg;
  logic [7:0]   ir;
  logic         pmem_ack = 1'b0;
  logic         dmem_ack = 1'b0;
  logic [W-1:0] pmem_rdata = '0;
  logic [W-1:0] dmem_rdata = '0;

  cpu_param #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetBar   (resetBar),
    .pmem_req   (pmem_req),
    .pmem_addr  (pmem_addr),
    .pmem_ack   (pmem_ack),
    .pmem_rdata (pmem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .areg       (areg),
    .breg       (breg),
    .xreg       (xreg),
    .qreg       (qreg),
    .ir         (ir),
    .qwrite     (qwrite),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  pmem [256];
  logic [7:0]  dmem [256];
  bit          dwr  [256];
  int          p_delay = 0, d_delay = 0, p_cnt = 0, d_cnt = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] exp_w [$];
  logic [7:0]  prog_q [$];
  event        ev_wr;
  logic [7:0]  wr_addr, wr_data, wr0_addr, wr0_data;
  int          wr_cycles = 0, last_wr_cycles = 0, ins_cycles = 0;
  bit          in_wr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Program memory: ack after p_delay stall cycles, decided mid-cycle.
  always @(negedge clk) begin
    if (pmem_req === 1'b1) begin
      pmem_rdata = pmem[pmem_addr];
      if (p_cnt >= p_delay) begin
        pmem_ack = 1'b1;
        p_cnt = 0;
      end else begin
        pmem_ack = 1'b0;
        p_cnt++;
      end
    end else begin
      pmem_ack = 1'b0;
      p_cnt = 0;
    end
  end

  // Data memory: unwritten locations read as addr ^ 0xC3.
  always @(negedge clk) begin
    if (dmem_req === 1'b1) begin
      dmem_rdata = dwr[dmem_addr] ? dmem[dmem_addr] : (dmem_addr ^ 8'hC3);
      if (d_cnt >= d_delay) begin
        dmem_ack = 1'b1;
        d_cnt = 0;
        if (dmem_we === 1'b1) begin
          dmem[dmem_addr] = dmem_wdata;
          dwr[dmem_addr] = 1'b1;
          wr_addr = dmem_addr;
          wr_data = dmem_wdata;
          -> ev_wr;
        end
      end else begin
        dmem_ack = 1'b0;
        d_cnt++;
      end
    end else begin
      dmem_ack = 1'b0;
      d_cnt = 0;
    end
  end

  always @(ev_wr) begin
    logic [15:0] e;
    if (exp_w.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL dmem_wr_extra: got write 0x%0h<=0x%0h, expected none", wr_addr, wr_data);
    end else begin
      e = exp_w.pop_front();
      chk("dmem_wr_addr", wr_addr, e[15:8]);
      chk("dmem_wr_data", wr_data, e[7:0]);
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (resetBar === 1'b1 && qwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL qwrite_extra: got pulse with q=0x%0h, expected none", qreg);
      end else begin
        e = exp_q.pop_front();
        chk("qwrite_q", qreg, e);
      end
    end
    if (dmem_req === 1'b1 && dmem_we === 1'b1) begin
      if (!in_wr) begin
        in_wr = 1'b1;
        wr_cycles = 1;
        wr0_addr = dmem_addr;
        wr0_data = dmem_wdata;
      end else begin
        wr_cycles++;
        chk("wr_addr_stable", dmem_addr, wr0_addr);
        chk("wr_data_stable", dmem_wdata, wr0_data);
      end
    end else if (in_wr) begin
      in_wr = 1'b0;
      last_wr_cycles = wr_cycles;
    end
    if ((pmem_req === 1'b1 && pmem_addr == 8'h04) || (dmem_req === 1'b1 && dmem_we === 1'b1))
      ins_cycles++;
  end

  task automatic load();
    for (int i = 0; i < 256; i++) pmem[i] = 8'h01;
    for (int i = 0; i < prog_q.size(); i++) pmem[i] = prog_q[i];
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_pc"}, pc, 0);
    chk({p, "_areg"}, areg, 0);
    chk({p, "_breg"}, breg, 0);
    chk({p, "_xreg"}, xreg, 0);
    chk({p, "_qreg"}, qreg, 0);
    chk({p, "_ir"}, ir, 0);
    chk({p, "_qwrite"}, qwrite, 0);
    chk({p, "_halted"}, halted, 0);
    chk({p, "_pmem_req"}, pmem_req, 0);
    chk({p, "_dmem_req"}, dmem_req, 0);
  endtask

  task automatic start(input string nm);
    resetBar = 1'b1;
    #1 resetBar = 1'b0;
    #1 chk_zero({nm, "_rst"});
    repeat (2) @(posedge clk);
    #2 resetBar = 1'b1;
  endtask

  task automatic run(input string nm, input int maxc, output int cyc);
    int c = 0;
    while (halted !== 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_halted"}, halted, 1);
    cyc = c - 1;
    @(negedge clk);
    chk({nm, "_q_left"}, exp_q.size(), 0);
    chk({nm, "_w_left"}, exp_w.size(), 0);
  endtask

  initial begin
    int cyc;
    int ins0;

    // A<=5; B<=3; A<=A+B; Q<=A (halt): 6 program bytes, 4 instructions
    prog_q = '{8'h00, 8'h05, 8'h20, 8'h03, 8'h14, 8'h69};
    load();
    exp_q.push_back(8'h08);
    start("t1");
    run("t1", 40, cyc);
    chk("t1_cycles", cyc, 8);
    chk("t1_pc", pc, 8'h06);
    chk("t1_areg", areg, 8'h08);
    chk("t1_breg", breg, 8'h03);

    // 200+100 -> 44 c=1 (JC taken to 0x0A); 44-100 -> 200 c=0 (JC falls through)
    prog_q = '{8'h00, 8'hC8, 8'h20, 8'h64, 8'h14, 8'h68, 8'hE0, 8'h0A, 8'h61, 8'hBB,
               8'h18, 8'h68, 8'hE0, 8'h10, 8'h61, 8'h5A, 8'h61, 8'hA5};
    load();
    exp_q.push_back(8'h2C);
    exp_q.push_back(8'hC8);
    exp_q.push_back(8'h5A);
    start("t2");
    run("t2", 60, cyc);
    chk("t2_cycles", cyc, 18);
    chk("t2_pc", pc, 8'h10);
    chk("t2_areg", areg, 8'hC8);
    chk("t2_breg", breg, 8'h64);

    // countdown: loop A-=1; Q<=A; JZ 0x0A; JMP 4 -- end at 0x0A writes Q=0x77
    prog_q = '{8'h00, 8'h03, 8'h20, 8'h01, 8'h18, 8'h68, 8'hC0, 8'h0A, 8'hA0, 8'h04,
               8'h61, 8'h77};
    load();
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h77);
    start("t3");
    run("t3", 80, cyc);
    chk("t3_cycles", cyc, 28);
    chk("t3_pc", pc, 8'h0C);
    chk("t3_areg", areg, 8'h00);

    // MEM<=A at X=0x10 with 3 wait states, then read it back into A and Q
    d_delay = 3;
    prog_q = '{8'h00, 8'h5C, 8'h40, 8'h10, 8'h88, 8'h04, 8'h69};
    load();
    exp_w.push_back(16'h105C);
    exp_q.push_back(8'h5C);
    ins0 = ins_cycles;
    start("t4");
    run("t4", 80, cyc);
    chk("t4_cycles", cyc, 16);
    chk("t4_wr_req_cycles", last_wr_cycles, 4);
    chk("t4_wr_instr_cycles", ins_cycles - ins0, 5);
    chk("t4_pc", pc, 8'h07);
    chk("t4_xreg", xreg, 8'h10);
    chk("t4_areg", areg, 8'h5C);
    d_delay = 0;

    // X<=0x20 (ir[1]); Q<=X; X<=0xFF; A<=MEM (ir[1]); Q<=A (halt)
    prog_q = '{8'h42, 8'h20, 8'h70, 8'h40, 8'hFF, 8'h06, 8'h69};
    load();
`ifdef CPU_PARAM_XINC_EN
    exp_q.push_back(8'h21);
`else
    exp_q.push_back(8'h20);
`endif
    exp_q.push_back(8'h3C);
    start("t5");
    run("t5", 60, cyc);
    chk("t5_cycles", cyc, 10);
    chk("t5_pc", pc, 8'h07);
    chk("t5_areg", areg, 8'h3C);
`ifdef CPU_PARAM_XINC_EN
    chk("t5_xreg", xreg, 8'h00);
`else
    chk("t5_xreg", xreg, 8'hFF);
`endif

    // reset while the fetch at pc=2 is stalled, then restart from address 0
    prog_q = '{8'h00, 8'h11, 8'h61, 8'h99};
    load();
    start("t6");
    for (int i = 0; i < 20 && pc !== 8'h02; i++) begin
      @(posedge clk);
      #1;
    end
    chk("t6_reach_pc2", pc, 8'h02);
    p_delay = 50;
    repeat (3) @(negedge clk);
    chk("t6_stall_req", pmem_req, 1);
    chk("t6_stall_addr", pmem_addr, 8'h02);
    chk("t6_stall_areg", areg, 8'h11);
    #2 resetBar = 1'b0;
    #1 chk_zero("t6_abort");
    repeat (2) @(posedge clk);
    p_delay = 0;
    exp_q.push_back(8'h99);
    #2 resetBar = 1'b1;
    #1;
    chk("t6_refetch_req", pmem_req, 1);
    chk("t6_refetch_addr", pmem_addr, 8'h00);
    run("t6", 40, cyc);
    chk("t6_cycles", cyc, 4);
    chk("t6_pc", pc, 8'h04);
    chk("t6_areg", areg, 8'h11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
